// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Load misses stall, wait MISS_LATENCY cycles, then refill a 16-byte line
// one word per cycle through the memory's combinational read port.
// Optional feature macro: DCACHE_STATS_EN (hit/miss statistics counters).
module data_cache #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned SETS         = 64,
  parameter int unsigned LINE_WORDS   = 4,
  parameter int unsigned MISS_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic             cpu_memtype,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wd,
  output logic [WIDTH-1:0] cpu_rd,
  output logic             stall,
  output logic             misalign,
  output logic             mem_we,
  output logic             mem_memtype,
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned TAGW = WIDTH - 4 - IDXW;
  localparam int unsigned WCW  = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
  localparam logic [WCW-1:0] WLAST = (MISS_LATENCY > 0) ? WCW'(MISS_LATENCY - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FILL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SETS-1:0]  r_valid;
  logic [TAGW-1:0]  r_tag  [SETS];
  logic [WIDTH-1:0] r_data [SETS][LINE_WORDS];
  logic [WIDTH-5:0] r_line;
  logic [WCW-1:0]   r_wcnt;
  logic [1:0]       r_fcnt;

  logic [IDXW-1:0]  w_idx;
  logic [TAGW-1:0]  w_tag;
  logic [1:0]       w_word;
  logic [1:0]       w_lane;
  logic [IDXW-1:0]  w_fidx;
  logic [TAGW-1:0]  w_ftag;
  logic             w_hit;
  logic             w_mis;
  logic             w_acc;
  logic             w_ld_hit;
  logic             w_ld_miss;
  logic             w_st;
  logic [WIDTH-1:0] w_rword;
  logic [7:0]       w_rbyte;
  logic [WIDTH-1:0] w_merged;

  assign w_idx     = cpu_addr[4+IDXW-1:4];
  assign w_tag     = cpu_addr[WIDTH-1:4+IDXW];
  assign w_word    = cpu_addr[3:2];
  assign w_lane    = cpu_addr[1:0];
  assign w_fidx    = r_line[IDXW-1:0];
  assign w_ftag    = r_line[WIDTH-5:IDXW];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_mis     = cpu_req && !cpu_memtype && (w_lane != 2'b00);
  assign w_acc     = cpu_req && !w_mis;
  assign w_ld_hit  = (r_state == S_IDLE) && w_acc && !cpu_we && w_hit;
  assign w_ld_miss = (r_state == S_IDLE) && w_acc && !cpu_we && !w_hit;
  assign w_st      = (r_state == S_IDLE) && w_acc && cpu_we;
  assign w_rword   = r_data[w_idx][w_word];
  assign w_rbyte   = w_rword[{w_lane, 3'b000} +: 8];

  // Byte-store merge of the resident word.
  always_comb begin
    w_merged = w_rword;
    w_merged[{w_lane, 3'b000} +: 8] = cpu_wd[7:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_ld_miss) w_next = (MISS_LATENCY > 0) ? S_WAIT : S_FILL;
      S_WAIT: if (r_wcnt == WLAST) w_next = S_FILL;
      S_FILL: if (r_fcnt == 2'd3) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: memory port mirrors the CPU in IDLE, drives the refill otherwise.
  always_comb begin
    stall       = 1'b0;
    misalign    = 1'b0;
    mem_we      = 1'b0;
    mem_memtype = cpu_memtype;
    mem_a       = cpu_addr;
    mem_wd      = cpu_wd;
    cpu_rd      = '0;
    if (rst_n) begin
      misalign = w_mis;
      case (r_state)
        S_IDLE: begin
          mem_we = w_st;
          stall  = w_ld_miss;
          if (w_ld_hit) cpu_rd = cpu_memtype ? {{(WIDTH-8){1'b0}}, w_rbyte} : w_rword;
        end
        S_WAIT: begin
          stall       = 1'b1;
          mem_memtype = 1'b0;
          mem_a       = {r_line, 4'h0};
          mem_wd      = '0;
        end
        S_FILL: begin
          stall       = 1'b1;
          mem_memtype = 1'b0;
          mem_a       = {r_line, r_fcnt, 2'b00};
          mem_wd      = '0;
        end
        default: stall = 1'b0;
      endcase
    end
  end

  // Refill control: line base, wait/fill counters and valid bits.
  // The indexed line is invalidated at miss time so a partial refill is never visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_line  <= '0;
      r_wcnt  <= '0;
      r_fcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ld_miss) begin
            r_valid[w_idx] <= 1'b0;
            r_line         <= cpu_addr[WIDTH-1:4];
            r_wcnt         <= '0;
            r_fcnt         <= '0;
          end
        end
        S_WAIT: r_wcnt <= r_wcnt + WCW'(1);
        S_FILL: begin
          r_fcnt <= r_fcnt + 2'd1;
          if (r_fcnt == 2'd3) r_valid[w_fidx] <= 1'b1;
        end
        default: r_fcnt <= '0;
      endcase
    end
  end

  // Tag and data storage: refill words and store-hit updates.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == S_FILL)) begin
      r_data[w_fidx][r_fcnt] <= mem_rd;
      if (r_fcnt == 2'd3) r_tag[w_fidx] <= w_ftag;
    end else if (rst_n && w_st && w_hit) begin
      r_data[w_idx][w_word] <= cpu_memtype ? w_merged : cpu_wd;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;

  // Statistics: load hits in IDLE and IDLE-to-refill transitions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      if (w_ld_hit)  r_hits   <= r_hits + 32'd1;
      if (w_ld_miss) r_misses <= r_misses + 32'd1;
    end
  end

  assign hit_count  = r_hits;
  assign miss_count = r_misses;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed self-checking bench for data_cache with a
// byte-addressed memory model (2 KiB, aliased on addr[10:0]).
module tb_data_cache;

  localparam int unsigned L = 2;
`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_memtype;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        stall;
  logic        misalign;
  logic        mem_we;
  logic        mem_memtype;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [31:0] a_trace [0:31];

  logic [7:0]  mem [0:2047];
  logic [10:0] ma;

  always #5 clk = ~clk;

  data_cache #(
    .WIDTH(32),
    .SETS(64),
    .LINE_WORDS(4),
    .MISS_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_memtype(cpu_memtype),
    .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd),
    .stall(stall),
    .misalign(misalign),
    .mem_we(mem_we),
    .mem_memtype(mem_memtype),
    .mem_a(mem_a),
    .mem_wd(mem_wd),
    .mem_rd(mem_rd),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  assign ma     = mem_a[10:0];
  assign mem_rd = {mem[ma + 11'd3], mem[ma + 11'd2], mem[ma + 11'd1], mem[ma]};

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_memtype) begin
        mem[ma] = mem_wd[7:0];
      end else begin
        mem[ma]          = mem_wd[7:0];
        mem[ma + 11'd1]  = mem_wd[15:8];
        mem[ma + 11'd2]  = mem_wd[23:16];
        mem[ma + 11'd3]  = mem_wd[31:24];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a load, counts stalled cycles (bounded), captures data, then
  // lets the replayed hit take its edge and drops the request.
  task automatic run_load(input logic [31:0] addr, input logic bt,
                          output int unsigned stalls, output logic [31:0] rd);
    cpu_req     = 1'b1;
    cpu_we      = 1'b0;
    cpu_memtype = bt;
    cpu_addr    = addr;
    cpu_wd      = '0;
    #1;
    stalls = 0;
    while (stall && stalls < 32) begin
      a_trace[stalls] = mem_a;
      stalls++;
      step();
    end
    rd = cpu_rd;
    step();
    cpu_req = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_memtype = 1'b0;
    cpu_addr = 32'h0001_0001; cpu_wd = 32'hFFFF_FFFF;
    step(); step();
    n_total++; if (misalign !== 1'b0) $display("FAIL rst_misalign: got %b want 0", misalign); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
    n_total++; if (hit_count !== 32'd0) $display("FAIL rst_hits: got %0d want 0", hit_count); else n_pass++;
    n_total++; if (miss_count !== 32'd0) $display("FAIL rst_misses: got %0d want 0", miss_count); else n_pass++;
    cpu_we = 1'b0; cpu_addr = 32'h0001_0000;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (cpu_rd !== 32'd0) $display("FAIL rst_cpu_rd: got %h want 0", cpu_rd); else n_pass++;
    step();
    rst_n = 1'b1; cpu_req = 1'b0;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL idle_noreq_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL idle_noreq_mem_we: got %b want 0", mem_we); else n_pass++;
    n_total++; if (cpu_rd !== 32'd0) $display("FAIL idle_noreq_cpu_rd: got %h want 0", cpu_rd); else n_pass++;
  endtask

  task automatic test_miss_fill();
    int unsigned s;
    logic [31:0] rd;
    run_load(32'h0001_0000, 1'b0, s, rd);
    n_total++; if (s !== 7) $display("FAIL miss_stall_cycles: got %0d want 7", s); else n_pass++;
    n_total++; if (a_trace[0] !== 32'h0001_0000) $display("FAIL miss_mem_a_idle: got %h want 00010000", a_trace[0]); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (a_trace[3+i] !== 32'h0001_0000 + 32'(4*i))
        $display("FAIL fill_mem_a[%0d]: got %h want %h", i, a_trace[3+i], 32'h0001_0000 + 32'(4*i));
      else n_pass++;
    end
    n_total++; if (rd !== 32'h4433_2211) $display("FAIL miss_replay_rd: got %h want 44332211", rd); else n_pass++;
    n_total++; if (miss_count !== (STATS ? 32'd1 : 32'd0)) $display("FAIL miss_count_1: got %0d want %0d", miss_count, STATS ? 1 : 0); else n_pass++;
    n_total++; if (hit_count !== (STATS ? 32'd1 : 32'd0)) $display("FAIL hit_count_1: got %0d want %0d", hit_count, STATS ? 1 : 0); else n_pass++;
  endtask

  task automatic test_byte_hit();
    int unsigned s;
    logic [31:0] rd;
    run_load(32'h0001_0002, 1'b1, s, rd);
    n_total++; if (s !== 0) $display("FAIL byte_hit_stall: got %0d want 0", s); else n_pass++;
    n_total++; if (rd !== 32'h0000_0033) $display("FAIL byte_hit_rd: got %h want 00000033", rd); else n_pass++;
    n_total++; if (hit_count !== (STATS ? 32'd2 : 32'd0)) $display("FAIL hit_count_2: got %0d want %0d", hit_count, STATS ? 2 : 0); else n_pass++;
  endtask

  task automatic test_store_hit();
    int unsigned s;
    logic [31:0] rd;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_memtype = 1'b0;
    cpu_addr = 32'h0001_0004; cpu_wd = 32'hDEAD_BEEF;
    #1;
    n_total++; if (mem_we !== 1'b1) $display("FAIL st_hit_mem_we: got %b want 1", mem_we); else n_pass++;
    n_total++; if (mem_a !== 32'h0001_0004) $display("FAIL st_hit_mem_a: got %h want 00010004", mem_a); else n_pass++;
    n_total++; if (mem_wd !== 32'hDEAD_BEEF) $display("FAIL st_hit_mem_wd: got %h want deadbeef", mem_wd); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL st_hit_stall: got %b want 0", stall); else n_pass++;
    step();
    cpu_req = 1'b0;
    #1;
    n_total++;
    if ({mem[7], mem[6], mem[5], mem[4]} !== 32'hDEAD_BEEF)
      $display("FAIL st_hit_memory: got %h want deadbeef", {mem[7], mem[6], mem[5], mem[4]});
    else n_pass++;
    run_load(32'h0001_0004, 1'b0, s, rd);
    n_total++; if (s !== 0) $display("FAIL st_hit_reload_stall: got %0d want 0", s); else n_pass++;
    n_total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL st_hit_reload_rd: got %h want deadbeef", rd); else n_pass++;
  endtask

  task automatic test_store_miss();
    int unsigned s;
    logic [31:0] rd;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_memtype = 1'b1;
    cpu_addr = 32'h0001_0100; cpu_wd = 32'h1234_56AB;
    #1;
    n_total++; if (mem_we !== 1'b1) $display("FAIL st_miss_mem_we: got %b want 1", mem_we); else n_pass++;
    n_total++; if (mem_memtype !== 1'b1) $display("FAIL st_miss_memtype: got %b want 1", mem_memtype); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL st_miss_stall: got %b want 0", stall); else n_pass++;
    step();
    cpu_req = 1'b0;
    #1;
    n_total++; if (mem[11'h100] !== 8'hAB) $display("FAIL st_miss_mem_byte: got %h want ab", mem[11'h100]); else n_pass++;
    n_total++; if (mem[11'h101] !== 8'hC2) $display("FAIL st_miss_mem_neighbour: got %h want c2", mem[11'h101]); else n_pass++;
    run_load(32'h0001_0100, 1'b1, s, rd);
    n_total++; if (s !== 7) $display("FAIL no_alloc_stall: got %0d want 7", s); else n_pass++;
    n_total++; if (rd !== 32'h0000_00AB) $display("FAIL no_alloc_rd: got %h want 000000ab", rd); else n_pass++;
    n_total++; if (miss_count !== (STATS ? 32'd2 : 32'd0)) $display("FAIL miss_count_2: got %0d want %0d", miss_count, STATS ? 2 : 0); else n_pass++;
    run_load(32'h0001_0101, 1'b1, s, rd);
    n_total++; if (s !== 0) $display("FAIL byte_hit2_stall: got %0d want 0", s); else n_pass++;
    n_total++; if (rd !== 32'h0000_00C2) $display("FAIL byte_hit2_rd: got %h want 000000c2", rd); else n_pass++;
    n_total++; if (hit_count !== (STATS ? 32'd5 : 32'd0)) $display("FAIL hit_count_5: got %0d want %0d", hit_count, STATS ? 5 : 0); else n_pass++;
  endtask

  task automatic test_conflict();
    int unsigned s;
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] exp_rd;
    for (int i = 0; i < 5; i++) begin
      a      = (i % 2 == 0) ? 32'h0001_0400 : 32'h0001_0000;
      exp_rd = (i % 2 == 0) ? 32'hC0C1_C2C3 : 32'h4433_2211;
      run_load(a, 1'b0, s, rd);
      n_total++; if (s !== 7) $display("FAIL conflict_stall[%0d]: got %0d want 7", i, s); else n_pass++;
      n_total++; if (rd !== exp_rd) $display("FAIL conflict_rd[%0d]: got %h want %h", i, rd, exp_rd); else n_pass++;
      n_total++;
      if (miss_count !== (STATS ? 32'(3 + i) : 32'd0))
        $display("FAIL conflict_miss_count[%0d]: got %0d want %0d", i, miss_count, STATS ? 3 + i : 0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_fill();
    int unsigned s;
    logic [31:0] rd;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_memtype = 1'b0;
    cpu_addr = 32'h0001_0000; cpu_wd = '0;
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL abort_miss_stall: got %b want 1", stall); else n_pass++;
    step(); step(); step(); step();
    n_total++; if (mem_a !== 32'h0001_0004) $display("FAIL abort_fill1_mem_a: got %h want 00010004", mem_a); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL abort_rst_stall: got %b want 0", stall); else n_pass++;
    step();
    rst_n = 1'b1; cpu_req = 1'b0;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL abort_idle_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (miss_count !== 32'd0) $display("FAIL abort_miss_count: got %0d want 0", miss_count); else n_pass++;
    run_load(32'h0001_0400, 1'b0, s, rd);
    n_total++; if (s !== 7) $display("FAIL abort_old_line_stall: got %0d want 7", s); else n_pass++;
    n_total++; if (rd !== 32'hC0C1_C2C3) $display("FAIL abort_old_line_rd: got %h want c0c1c2c3", rd); else n_pass++;
    run_load(32'h0001_0000, 1'b0, s, rd);
    n_total++; if (s !== 7) $display("FAIL abort_reload_stall: got %0d want 7", s); else n_pass++;
    n_total++; if (rd !== 32'h4433_2211) $display("FAIL abort_reload_rd: got %h want 44332211", rd); else n_pass++;
    n_total++; if (miss_count !== (STATS ? 32'd2 : 32'd0)) $display("FAIL abort_reload_misses: got %0d want %0d", miss_count, STATS ? 2 : 0); else n_pass++;
  endtask

  task automatic test_misalign();
    int unsigned s;
    logic [31:0] rd;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_memtype = 1'b0;
    cpu_addr = 32'h0001_0001; cpu_wd = '0;
    #1;
    n_total++; if (misalign !== 1'b1) $display("FAIL mis_ld_flag: got %b want 1", misalign); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL mis_ld_mem_we: got %b want 0", mem_we); else n_pass++;
    n_total++; if (cpu_rd !== 32'd0) $display("FAIL mis_ld_rd: got %h want 0", cpu_rd); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL mis_ld_stall: got %b want 0", stall); else n_pass++;
    step();
    cpu_we = 1'b1; cpu_addr = 32'h0001_0002; cpu_wd = 32'h5555_5555;
    #1;
    n_total++; if (mem_we !== 1'b0) $display("FAIL mis_st_mem_we: got %b want 0", mem_we); else n_pass++;
    n_total++; if (misalign !== 1'b1) $display("FAIL mis_st_flag: got %b want 1", misalign); else n_pass++;
    step();
    cpu_req = 1'b0;
    #1;
    n_total++; if (mem[11'h002] !== 8'h33) $display("FAIL mis_st_memory: got %h want 33", mem[11'h002]); else n_pass++;
    n_total++; if (hit_count !== (STATS ? 32'd2 : 32'd0)) $display("FAIL mis_hit_count: got %0d want %0d", hit_count, STATS ? 2 : 0); else n_pass++;
    n_total++; if (miss_count !== (STATS ? 32'd2 : 32'd0)) $display("FAIL mis_miss_count: got %0d want %0d", miss_count, STATS ? 2 : 0); else n_pass++;
    cpu_memtype = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0001_0001; cpu_req = 1'b1;
    #1;
    n_total++; if (misalign !== 1'b0) $display("FAIL byte_never_misaligned: got %b want 0", misalign); else n_pass++;
    run_load(32'h0001_0001, 1'b1, s, rd);
    n_total++; if (s !== 0) $display("FAIL byte_odd_stall: got %0d want 0", s); else n_pass++;
    n_total++; if (rd !== 32'h0000_0022) $display("FAIL byte_odd_rd: got %h want 00000022", rd); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    test_reset();
    test_miss_fill();
    test_byte_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_in_fill();
    test_misalign();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
